// File: rtl/clock_divider_if.sv
// rtl/clock_divider_if.sv - strobe output bundle of clock_divider (squareOUT only with CLOCK_DIVIDER_SQUARE_EN)
interface clock_divider_if;
    logic clkOUT;
`ifdef CLOCK_DIVIDER_SQUARE_EN
    logic squareOUT;
`endif

`ifdef CLOCK_DIVIDER_SQUARE_EN
    modport master (output clkOUT, output squareOUT);
    modport slave  (input  clkOUT, input  squareOUT);
`else
    modport master (output clkOUT);
    modport slave  (input  clkOUT);
`endif
endinterface

// File: rtl/clock_divider.sv
// rtl/clock_divider.sv - one-cycle enable strobe every VALUE clocks; optional square output via CLOCK_DIVIDER_SQUARE_EN
module clock_divider #(
    parameter int VALUE = 5
) (
    input  logic              clkIN,
    input  logic              nResetIN,
    clock_divider_if.master   div_if
);

    localparam int            CW   = (VALUE > 1) ? $clog2(VALUE) : 1;
    localparam logic [CW-1:0] LAST = CW'(VALUE - 1);

    generate
        if (VALUE < 1) begin : g_bad_value
            $error("clock_divider: VALUE must be >= 1");
        end
    endgenerate

    logic [CW-1:0] r_cnt;
    logic          r_strobe;
    logic          w_terminal;

    assign w_terminal = (r_cnt == LAST);

    // nResetIN doubles as the run/hold gate, so phase always restarts from 0
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else if (w_terminal) begin
            r_cnt    <= '0;
            r_strobe <= 1'b1;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
            r_strobe <= 1'b0;
        end
    end

    assign div_if.clkOUT = r_strobe;

`ifdef CLOCK_DIVIDER_SQUARE_EN
    logic r_square;

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            r_square <= 1'b0;
        end else if (w_terminal) begin
            r_square <= ~r_square;
        end
    end

    assign div_if.squareOUT = r_square;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// tb/tb_clock_divider.sv - directed bench for clock_divider at VALUE 5, 1, 7 and 4
module tb_clock_divider;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int vectors     = 0;
    int miscompares = 0;
    int strobes_5   = 0;
    int strobes_7   = 0;

    always #5 clk = ~clk;

    clock_divider_if if_5 ();
    clock_divider_if if_1 ();
    clock_divider_if if_7 ();
    clock_divider_if if_4 ();

    clock_divider #(.VALUE(5)) dut_5 (.clkIN(clk), .nResetIN(rst_n), .div_if(if_5));
    clock_divider #(.VALUE(1)) dut_1 (.clkIN(clk), .nResetIN(rst_n), .div_if(if_1));
    clock_divider #(.VALUE(7)) dut_7 (.clkIN(clk), .nResetIN(rst_n), .div_if(if_7));
    clock_divider #(.VALUE(4)) dut_4 (.clkIN(clk), .nResetIN(rst_n), .div_if(if_4));

    task automatic check(input string tag, input int k, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s k=%0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // k = rising edges since the last release; k == 0 means reset held
    task automatic check_all(input int k);
        check("div5_clkOUT", k, if_5.clkOUT, (k > 0) && (k % 5 == 0));
        check("div1_clkOUT", k, if_1.clkOUT, (k > 0));
        check("div7_clkOUT", k, if_7.clkOUT, (k > 0) && (k % 7 == 0));
        check("div4_clkOUT", k, if_4.clkOUT, (k > 0) && (k % 4 == 0));
`ifdef CLOCK_DIVIDER_SQUARE_EN
        check("div4_squareOUT", k, if_4.squareOUT, ((k / 4) % 2) == 1);
`endif
        if (if_5.clkOUT === 1'b1) strobes_5++;
        if (if_7.clkOUT === 1'b1) strobes_7++;
    endtask

    initial begin
        // asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1 check_all(0);
        repeat (2) begin
            @(negedge clk);
            check_all(0);
        end

        // free run, sampled on the falling edge
        @(negedge clk);
        #1 rst_n = 1'b1;
        strobes_5 = 0;
        strobes_7 = 0;
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            check_all(k);
            if (k == 70) begin
                check_int("div5_strobe_count_70", strobes_5, 14);
                check_int("div7_strobe_count_70", strobes_7, 10);
            end
        end

        // reset while div5 and div1 strobes are high: both drop at once
        #1 rst_n = 1'b0;
        #1 check_all(0);
        repeat (3) begin
            @(negedge clk);
            check_all(0);
        end

        // release: phase restarts from 0
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            check_all(k);
        end

        // reset held across div5's terminal-count edge: no strobe
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_all(0);

        #1 rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check_all(k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
